// File: rtl/fu_accum_ctrl_pkg.sv
// Shared definitions for the accumulate controller: the request opcode encoding
// and the control record that travels from the issue stage to the compute stage.
package fu_accum_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_ACCUM = 2'b01,
    OP_READ  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  // Widths of the address and operand depend on instance parameters, so they
  // ride in separate registers beside this record.
  typedef struct packed {
    logic valid;
    op_e  op;
    logic fwd_hit;
  } stage_ctrl_t;

  function automatic logic op_reads(input op_e op);
    return (op == OP_ACCUM) || (op == OP_READ);
  endfunction

  function automatic logic op_writes(input op_e op);
    return (op == OP_WRITE) || (op == OP_ACCUM);
  endfunction

endpackage

// File: rtl/fu_accum_ctrl_if.sv
// Request, response and storage-port bundle of the accumulate controller.
// The slave modport is the controller's view; the master modport is the environment's view.
interface fu_accum_ctrl_if #(
  parameter int addr_width = 9,
  parameter int data_width = 1024
);
  import fu_accum_ctrl_pkg::*;

  // Handshakes: a beat transfers on a rising CLK edge where valid and ready are both
  // high; the sender holds its payload stable while valid is high and ready is low,
  // and ready may depend on state but never waits for valid.
  logic                  req_valid;
  logic                  req_ready;
  op_e                   req_op;
  logic [addr_width-1:0] req_addr;
  logic [data_width-1:0] req_data;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [data_width-1:0] resp_data;

  logic                  bram_write_en;
  logic [addr_width-1:0] bram_write_addr;
  logic [data_width-1:0] bram_write_data;
  logic                  bram_read_en;
  logic [addr_width-1:0] bram_read_addr;
  logic [data_width-1:0] bram_read_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready,
    output resp_valid, resp_data,
    input  resp_ready,
    output bram_write_en, bram_write_addr, bram_write_data,
    output bram_read_en, bram_read_addr,
    input  bram_read_data
  );

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready,
    input  resp_valid, resp_data,
    output resp_ready,
    input  bram_write_en, bram_write_addr, bram_write_data,
    input  bram_read_en, bram_read_addr,
    output bram_read_data
  );

endinterface

// File: rtl/fu_accum_ctrl_lane_add.sv
// Per-lane wrapping adder: each lane_width slice adds independently, carries
// never cross a lane boundary. data_width must be a multiple of lane_width.
module fu_lane_add #(
  parameter int data_width = 1024,
  parameter int lane_width = 32
) (
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic [data_width-1:0] sum
);

  localparam int lanes = data_width / lane_width;

  for (genvar i = 0; i < lanes; i++) begin : g_lane
    assign sum[i*lane_width +: lane_width] =
      a[i*lane_width +: lane_width] + b[i*lane_width +: lane_width];
  end

endmodule

// File: rtl/fu_accum_ctrl.sv
// Two-stage read-modify-write controller over a synchronous storage port:
// S1 accepts and issues the read, S2 computes, writes back or fills the response.
module fu_accum_ctrl
  import fu_accum_ctrl_pkg::*;
#(
  parameter int addr_width = 9,
  parameter int data_width = 1024,
  parameter int lane_width = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  fu_accum_ctrl_if.slave  bus
);

  logic                  ready_q;
  stage_ctrl_t           s2_q;
  logic [addr_width-1:0] s2_addr_q;
  logic [data_width-1:0] s2_data_q;
  logic [data_width-1:0] fwd_data_q;
  logic                  resp_valid_q;
  logic [data_width-1:0] resp_data_q;

  logic                  stall;
  logic                  accept;
  logic                  s1_rd;
  logic                  s2_wr;
  logic                  s2_resp;
  logic                  fwd_hit;
  logic [data_width-1:0] old_word;
  logic [data_width-1:0] sum_word;
  logic [data_width-1:0] wr_word;

  // Only a READ waiting on a full, unconsumed response register can block the pipe.
  assign stall   = s2_q.valid && (s2_q.op == OP_READ) && resp_valid_q && !bus.resp_ready;
  assign accept  = bus.req_valid && bus.req_ready;
  assign s1_rd   = accept && op_reads(bus.req_op);
  assign s2_wr   = s2_q.valid && op_writes(s2_q.op);
  assign s2_resp = s2_q.valid && (s2_q.op == OP_READ) && !stall;

  // The storage returns pre-write data on a same-cycle collision, so the value
  // written by S2 is captured and substituted when the colliding request arrives.
  assign fwd_hit  = s1_rd && s2_wr && (bus.req_addr == s2_addr_q);
  assign old_word = s2_q.fwd_hit ? fwd_data_q : bus.bram_read_data;
  assign wr_word  = (s2_q.op == OP_ACCUM) ? sum_word : s2_data_q;

  fu_lane_add #(
    .data_width (data_width),
    .lane_width (lane_width)
  ) u_lane_add (
    .a   (old_word),
    .b   (s2_data_q),
    .sum (sum_word)
  );

  assign bus.req_ready       = ready_q && !stall;
  assign bus.bram_read_en    = s1_rd;
  assign bus.bram_read_addr  = s1_rd ? bus.req_addr : '0;
  assign bus.bram_write_en   = s2_wr;
  assign bus.bram_write_addr = s2_wr ? s2_addr_q : '0;
  assign bus.bram_write_data = s2_wr ? wr_word : '0;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_data       = resp_data_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ready_q    <= 1'b0;
      s2_q       <= '0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      ready_q <= 1'b1;
      if (!stall) begin
        // NOPs are accepted but never occupy S2.
        s2_q.valid   <= accept && (bus.req_op != OP_NOP);
        s2_q.op      <= bus.req_op;
        s2_q.fwd_hit <= fwd_hit;
        if (accept) begin
          s2_addr_q <= bus.req_addr;
          s2_data_q <= bus.req_data;
        end
        if (fwd_hit) begin
          fwd_data_q <= wr_word;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else if (s2_resp) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= old_word;
    end else if (resp_valid_q && bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fu_accum_ctrl.sv
// Directed bench for fu_accum_ctrl with a behavioural storage model and a
// response scoreboard fed by the stimulus and drained by an independent monitor.
module tb_fu_accum_ctrl;
  import fu_accum_ctrl_pkg::*;

  localparam int AW = 9;
  localparam int DW = 128;
  localparam int LW = 32;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int rd_count = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  fu_accum_ctrl_if #(.addr_width(AW), .data_width(DW)) bus();

  fu_accum_ctrl #(
    .addr_width (AW),
    .data_width (DW),
    .lane_width (LW)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- storage model: sync read, read-before-write, hold when idle ----------------
  always @(posedge CLK) begin
    if (bus.bram_read_en) begin
      bus.bram_read_data <= mem[bus.bram_read_addr];
      rd_count <= rd_count + 1;
    end
    if (bus.bram_write_en) begin
      mem[bus.bram_write_addr] <= bus.bram_write_data;
      wr_count <= wr_count + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor samples just before the rising edge, after all drivers have settled.
  always @(negedge CLK) begin
    logic [DW-1:0] e;
    #3;
    if (RST_N && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %h want no response", bus.resp_data);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", bus.resp_data, e);
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send(input op_e op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_data  = data;
    #1;
    while (!bus.req_ready && guard < 50) begin
      @(negedge CLK);
      #1;
      guard++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b want 1", bus.req_ready);
    end
    @(negedge CLK);
    bus.req_valid = 1'b0;
  endtask

  task automatic read_exp(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    send(OP_READ, addr, '0);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses left want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int r0;
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_NOP;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;

    // Reset: outputs quiet even with an ACCUM offered.
    repeat (2) @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ACCUM;
    bus.req_addr  = 9'd5;
    bus.req_data  = {4{32'h1}};
    #1;
    chk("rst_req_ready",  DW'(bus.req_ready), '0);
    chk("rst_resp_valid", DW'(bus.resp_valid), '0);
    chk("rst_resp_data",  bus.resp_data, '0);
    chk("rst_rd_en",      DW'(bus.bram_read_en), '0);
    chk("rst_wr_en",      DW'(bus.bram_write_en), '0);
    chk("rst_rd_addr",    DW'(bus.bram_read_addr), '0);
    chk("rst_wr_addr",    DW'(bus.bram_write_addr), '0);
    chk("rst_wr_data",    bus.bram_write_data, '0);
    bus.req_valid = 1'b0;
    RST_N = 1'b1;
    #1;
    chk("ready_before_edge", DW'(bus.req_ready), '0);
    @(posedge CLK);
    #1;
    chk("ready_after_edge", DW'(bus.req_ready), DW'(1'b1));
    @(negedge CLK);

    // Write then accumulate then read, back to back.
    send(OP_WRITE, 9'd5, {4{32'h0000_0010}});
    send(OP_ACCUM, 9'd5, {4{32'h0000_0003}});
    read_exp(9'd5, {4{32'h0000_0013}});
    drain();

    // Four consecutive accumulates to one address.
    send(OP_WRITE, 9'd7, '0);
    for (int i = 0; i < 4; i++) send(OP_ACCUM, 9'd7, {4{32'h1}});
    read_exp(9'd7, {4{32'h4}});
    drain();

    // Lane wrap without carry into the neighbouring lane.
    send(OP_WRITE, 9'd11, {32'h5, 32'h6, 32'h7, 32'hFFFF_FFFF});
    send(OP_ACCUM, 9'd11, {96'h0, 32'h2});
    read_exp(9'd11, {32'h5, 32'h6, 32'h7, 32'h1});
    send(OP_ACCUM, 9'd11, {4{32'hFFFF_FFFF}});
    read_exp(9'd11, {32'h4, 32'h5, 32'h6, 32'h0});
    drain();

    // Response back-pressure: two reads, consumer holds off for five cycles.
    send(OP_WRITE, 9'd3, {4{32'hA5A5_0003}});
    send(OP_WRITE, 9'd4, {4{32'h0000_0444}});
    drain();
    bus.resp_ready = 1'b0;
    read_exp(9'd3, {4{32'hA5A5_0003}});
    read_exp(9'd4, {4{32'h0000_0444}});
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ACCUM;
    bus.req_addr  = 9'd3;
    bus.req_data  = {4{32'h1}};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_req_ready",  DW'(bus.req_ready), '0);
      chk("hold_rd_en",      DW'(bus.bram_read_en), '0);
      chk("hold_wr_en",      DW'(bus.bram_write_en), '0);
      chk("hold_resp_valid", DW'(bus.resp_valid), DW'(1'b1));
      chk("hold_resp_data",  bus.resp_data, {4{32'hA5A5_0003}});
      @(negedge CLK);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    drain();
    read_exp(9'd3, {4{32'hA5A5_0003}});
    drain();

    // Reset while an ACCUM sits in S2: nothing is written.
    send(OP_WRITE, 9'd9, {4{32'h0000_0099}});
    drain();
    w0 = wr_count;
    send(OP_ACCUM, 9'd9, {4{32'h1}});
    #1;
    RST_N = 1'b0;
    #1;
    chk("midrst_wr_en",      DW'(bus.bram_write_en), '0);
    chk("midrst_req_ready",  DW'(bus.req_ready), '0);
    chk("midrst_resp_valid", DW'(bus.resp_valid), '0);
    @(negedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("midrst_no_write", DW'(wr_count - w0), '0);
    read_exp(9'd9, {4{32'h0000_0099}});
    drain();

    // NOP between writes: no storage activity, no response.
    w0 = wr_count;
    r0 = rd_count;
    send(OP_WRITE, 9'd12, {4{32'h0000_1200}});
    send(OP_NOP,   9'd12, {4{32'hDEAD_BEEF}});
    send(OP_WRITE, 9'd13, {4{32'h0000_1300}});
    repeat (3) @(negedge CLK);
    chk("nop_writes", DW'(wr_count - w0), DW'(2));
    chk("nop_reads",  DW'(rd_count - r0), '0);
    read_exp(9'd12, {4{32'h0000_1200}});
    read_exp(9'd13, {4{32'h0000_1300}});
    drain();

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
